// File: rtl/booth_encode_seq.sv
// booth_encode_seq: sequential radix-8 Booth encoder, one 4-bit select window per beat, lowest first.
module booth_encode_seq #(
    parameter int DATA_WIDTH = 32,
    localparam int NUM_GRP = (DATA_WIDTH + 3) / 3,
    localparam int GRP_W = $clog2(NUM_GRP),
    localparam int SH_W = $clog2(3 * NUM_GRP)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  is_signed,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            sel,
    output logic [GRP_W-1:0]      grp_idx,
    output logic [SH_W-1:0]       shift,
    output logic                  pp_neg,
    output logic                  pp_zero,
    output logic                  last
);
    localparam int BX_W = 3 * NUM_GRP + 1;
    typedef enum logic {IDLE, ENC} state_t;
    state_t state, state_nxt;
    logic [BX_W-1:0] sr, bx_in;
    logic ext, ext_r, accept, xfer, adv;
    logic [3:0] sel_nxt;
    assign ext = is_signed & b[DATA_WIDTH-1];
    assign bx_in = {{(BX_W-DATA_WIDTH-1){ext}}, b, 1'b0};
    assign in_ready = (state == IDLE);
    assign out_valid = (state == ENC);
    assign accept = in_valid & in_ready;
    assign xfer = out_valid & out_ready;
    assign adv = xfer & ~last & ~kill;
    assign sel_nxt = accept ? bx_in[3:0] : sr[3:0];
    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (accept) state_nxt = ENC;
        end else if (kill || (xfer && last)) begin
            state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // sr holds the windows still to be emitted; refill from the top with the sign/zero extension
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            ext_r   <= 1'b0;
            sel     <= 4'h0;
            grp_idx <= '0;
            shift   <= '0;
            pp_neg  <= 1'b0;
            pp_zero <= 1'b1;
            last    <= 1'b0;
        end else if (accept || adv) begin
            sr      <= accept ? {{3{ext}}, bx_in[BX_W-1:3]} : {{3{ext_r}}, sr[BX_W-1:3]};
            ext_r   <= accept ? ext : ext_r;
            sel     <= sel_nxt;
            pp_neg  <= sel_nxt[3] & (sel_nxt != 4'hF);
            pp_zero <= (sel_nxt == 4'h0) || (sel_nxt == 4'hF);
            grp_idx <= accept ? '0 : grp_idx + 1'b1;
            shift   <= accept ? '0 : shift + SH_W'(3);
            last    <= accept ? (NUM_GRP == 1) : (grp_idx == GRP_W'(NUM_GRP - 2));
        end
    end
endmodule

// File: tb/tb_booth_encode_seq.sv
// tb_booth_encode_seq: directed checks of the radix-8 Booth encoder windows, handshake, kill and reset.
module tb_booth_encode_seq;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, is_signed = 1'b0, kill = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, pp_neg, pp_zero, last;
    logic [31:0] b = '0;
    logic [3:0] sel, grp_idx;
    logic [5:0] shift;
    int checks = 0, failures = 0;
    longint acc;
    logic [3:0] seen [11];

    booth_encode_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .b(b),
        .is_signed(is_signed), .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .grp_idx(grp_idx), .shift(shift), .pp_neg(pp_neg), .pp_zero(pp_zero), .last(last)
    );

    always #5 clk = ~clk;

    function automatic int bval(input logic [3:0] s);
        case (s)
            4'h0, 4'hF: return 0;
            4'h1, 4'h2: return 1;
            4'h3, 4'h4: return 2;
            4'h5, 4'h6: return 3;
            4'h7:       return 4;
            4'h8:       return -4;
            4'h9, 4'hA: return -3;
            4'hB, 4'hC: return -2;
            default:    return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_ir"}, in_ready, 1);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_grp"}, grp_idx, 0);
        chk({tag, "_shift"}, shift, 0);
        chk({tag, "_neg"}, pp_neg, 0);
        chk({tag, "_zero"}, pp_zero, 1);
        chk({tag, "_last"}, last, 0);
    endtask

    // Called at a negedge; stop_at >= 0 leaves the operand at that window (optionally killing it).
    task automatic do_op(input logic [31:0] bv, input logic sg, input bit rnd,
                         input int stop_at, input bit use_kill);
        logic [33:0] bx;
        logic [3:0] es;
        int i, cyc;
        bx = {sg & bv[31], bv, 1'b0};
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; b = bv; is_signed = sg;
        @(negedge clk);
        in_valid = 1'b0; b = $urandom;
        acc = 0; i = 0; cyc = 0;
        while (i < 11 && cyc < 300) begin
            es = 4'(bx >> (3 * i));
            chk("out_valid", out_valid, 1);
            chk("in_ready_busy", in_ready, 0);
            chk("sel", sel, es);
            chk("grp_idx", grp_idx, i);
            chk("shift", shift, 3 * i);
            chk("last", last, i == 10);
            chk("pp_neg", pp_neg, es[3] && es != 4'hF);
            chk("pp_zero", pp_zero, es == 4'h0 || es == 4'hF);
            seen[i] = sel;
            if (i == stop_at) begin
                if (use_kill) begin
                    kill = 1'b1; out_ready = 1'b1;
                    @(negedge clk);
                    kill = 1'b0;
                    chk("kill_ov", out_valid, 0);
                    chk("kill_ir", in_ready, 1);
                end
                return;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
                acc += longint'(bval(sel)) <<< (3 * i);
                i++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("beats_done", i, 11);
        chk("after_ov", out_valid, 0);
        chk("after_ir", in_ready, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] rb;
        logic rs;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        // T1
        do_op(32'h0000_0007, 1'b0, 1'b0, -1, 1'b0);
        chk("t1_sum", acc, 64'd7);
        chk("t1_s0", seen[0], 4'hE);
        chk("t1_s1", seen[1], 4'h1);
        chk("t1_s2", seen[2], 4'h0);
        chk("t1_s10", seen[10], 4'h0);
        // T2
        do_op(32'hFFFF_FFFF, 1'b1, 1'b0, -1, 1'b0);
        chk("t2_sum", acc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_s0", seen[0], 4'hE);
        chk("t2_s1", seen[1], 4'hF);
        chk("t2_s10", seen[10], 4'hF);
        // T3
        do_op(32'hFFFF_FFFF, 1'b0, 1'b0, -1, 1'b0);
        chk("t3_sum", acc, 64'h0000_0000_FFFF_FFFF);
        chk("t3_s9", seen[9], 4'hF);
        chk("t3_s10", seen[10], 4'h7);
        // T4 random backpressure
        do_op(32'h1234_5678, 1'b0, 1'b1, -1, 1'b0);
        chk("t4_sum", acc, 64'h0000_0000_1234_5678);
        // T5 kill at window 4, kill in IDLE ignored, then a fresh operand
        do_op(32'hCAFE_F00D, 1'b1, 1'b0, 4, 1'b1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("idle_kill_ir", in_ready, 1);
        chk("idle_kill_ov", out_valid, 0);
        do_op(32'h8000_0000, 1'b1, 1'b0, -1, 1'b0);
        chk("t5_sum", acc, 64'hFFFF_FFFF_8000_0000);
        chk("t5_s0", seen[0], 4'h0);
        chk("t5_s10", seen[10], 4'hC);
        // T6 asynchronous reset mid-operand, then back-to-back random operands
        do_op(32'h9ABC_DEF1, 1'b1, 1'b0, 6, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            do_op(rb, rs, k[0], -1, 1'b0);
            chk("rand_sum", acc, rs ? longint'($signed(rb)) : longint'(rb));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
